// File: rtl/branch_predict_ctrl.sv
// Branch prediction sequencer: issues BHT lookups for fetch, tracks in-flight
// predicted branches, pairs them with execute resolutions and flushes on mispredict.
module branch_predict_ctrl #(
    parameter int PC_W   = 32,
    parameter int LOWER  = 5,
    parameter int DEPTH  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic [PC_W-1:0]   fetch_target,
    output logic              fetch_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_next_pc,
    output logic              bht_en,
    output logic [LOWER-1:0]  bht_read_addr,
    output logic [LOWER-1:0]  bht_write_addr,
    output logic              bht_was_taken,
    output logic              bht_jumped,
    output logic              bht_branch,
    input  logic              bht_prediction,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              resolve_jump,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [15:0]       branch_count,
    output logic [15:0]       mispredict_count,
    output logic              underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, LOOKUP} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     lk_pc_q, lk_pc_d;
    logic [PC_W-1:0]     lk_tgt_q, lk_tgt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [STAT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]   misp_cnt_q, misp_cnt_d;
    logic                underflow_q, underflow_d;

    logic [PC_W-1:0]     fifo_pc_q   [DEPTH];
    logic [PC_W-1:0]     fifo_pc_d   [DEPTH];
    logic [PC_W-1:0]     fifo_tgt_q  [DEPTH];
    logic [PC_W-1:0]     fifo_tgt_d  [DEPTH];
    logic                fifo_pred_q [DEPTH];
    logic                fifo_pred_d [DEPTH];

    logic                push;
    logic                pop;
    logic                accept;
    logic                mispredict;
    logic                actual;
    logic [PC_W-1:0]     head_pc;
    logic [PC_W-1:0]     head_tgt;
    logic                head_pred;

    assign head_pc   = fifo_pc_q[rd_ptr_q];
    assign head_tgt  = fifo_tgt_q[rd_ptr_q];
    assign head_pred = fifo_pred_q[rd_ptr_q];

    always_comb begin
        actual         = resolve_taken | resolve_jump;
        pop            = resolve_valid && (count_q != '0);
        mispredict     = pop && (actual != head_pred);
        // A mispredict squashes the lookup completing in the same cycle.
        push           = (state_q == LOOKUP) && !mispredict;
        fetch_ready    = (state_q == IDLE) && (count_q < (PTR_W+1)'(DEPTH)) && !mispredict;
        accept         = fetch_req && fetch_ready;

        pred_valid     = push;
        pred_taken     = push & bht_prediction;
        pred_next_pc   = '0;
        if (push) begin
            pred_next_pc = bht_prediction ? lk_tgt_q : lk_pc_q + PC_W'(4);
        end

        bht_en         = accept | pop;
        bht_read_addr  = accept ? fetch_pc[LOWER+1:2] : '0;
        bht_write_addr = pop ? head_pc[LOWER+1:2] : '0;
        bht_was_taken  = pop & resolve_taken;
        bht_jumped     = pop & resolve_jump;
        bht_branch     = pop;

        flush          = mispredict;
        redirect_pc    = '0;
        if (mispredict) begin
            redirect_pc = actual ? head_tgt : head_pc + PC_W'(4);
        end

        state_d  = accept ? LOOKUP : IDLE;
        lk_pc_d  = accept ? fetch_pc : lk_pc_q;
        lk_tgt_d = accept ? fetch_target : lk_tgt_q;

        wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q + (push ? (PTR_W+1)'(1) : '0) - (pop ? (PTR_W+1)'(1) : '0);
        if (mispredict) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        branch_cnt_d = branch_cnt_q;
        if (pop && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + STAT_W'(1);
        end
        misp_cnt_d = misp_cnt_q;
        if (mispredict && (misp_cnt_q != '1)) begin
            misp_cnt_d = misp_cnt_q + STAT_W'(1);
        end

        underflow_d = underflow_q | (resolve_valid && (count_q == '0));
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic entry_we;
            assign entry_we        = push && (wr_ptr_q == PTR_W'(gi));
            assign fifo_pc_d[gi]   = entry_we ? lk_pc_q : fifo_pc_q[gi];
            assign fifo_tgt_d[gi]  = entry_we ? lk_tgt_q : fifo_tgt_q[gi];
            assign fifo_pred_d[gi] = entry_we ? bht_prediction : fifo_pred_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    fifo_pc_q[gi]   <= '0;
                    fifo_tgt_q[gi]  <= '0;
                    fifo_pred_q[gi] <= 1'b0;
                end else begin
                    fifo_pc_q[gi]   <= fifo_pc_d[gi];
                    fifo_tgt_q[gi]  <= fifo_tgt_d[gi];
                    fifo_pred_q[gi] <= fifo_pred_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lk_pc_q      <= '0;
            lk_tgt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lk_pc_q      <= lk_pc_d;
            lk_tgt_q     <= lk_tgt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
            underflow_q  <= underflow_d;
        end
    end

    assign branch_count     = 16'(branch_cnt_q);
    assign mispredict_count = 16'(misp_cnt_q);
    assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed-vector bench for branch_predict_ctrl; statistics counters are narrowed
// so saturation is reachable in a short run.
module tb_branch_predict_ctrl;

    localparam int STAT_W = 6;
    localparam logic [31:0] SAT = 32'd63;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_target;
    logic        fetch_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        bht_en;
    logic [4:0]  bht_read_addr;
    logic [4:0]  bht_write_addr;
    logic        bht_was_taken;
    logic        bht_jumped;
    logic        bht_branch;
    logic        bht_prediction;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        resolve_jump;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;
    logic        underflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predict_ctrl #(.PC_W(32), .LOWER(5), .DEPTH(4), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_target(fetch_target),
        .fetch_ready(fetch_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .bht_en(bht_en), .bht_read_addr(bht_read_addr), .bht_write_addr(bht_write_addr),
        .bht_was_taken(bht_was_taken), .bht_jumped(bht_jumped), .bht_branch(bht_branch),
        .bht_prediction(bht_prediction),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_jump(resolve_jump),
        .flush(flush), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 0; fetch_pc = '0; fetch_target = '0; bht_prediction = 0;
        resolve_valid = 0; resolve_taken = 0; resolve_jump = 0;
    endtask

    logic [31:0] exp_next [4];
    logic [4:0]  exp_raddr [4];

    initial begin
        exp_next[0] = 32'h204;  exp_next[1] = 32'h1100;
        exp_next[2] = 32'h224;  exp_next[3] = 32'h1300;
        exp_raddr[0] = 5'd0; exp_raddr[1] = 5'd4; exp_raddr[2] = 5'd8; exp_raddr[3] = 5'd12;

        rst = 1; idle_inputs();
        step(); step();
        rst = 0; #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_bht_en", 32'(bht_en), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_branch_count", 32'(branch_count), 32'd0);
        chk("rst_misp_count", 32'(mispredict_count), 32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
        step();

        // first lookup: pc 0x40 predicted not-taken
        fetch_req = 1; fetch_pc = 32'h40; fetch_target = 32'h80; #1;
        chk("t1_bht_en", 32'(bht_en), 32'd1);
        chk("t1_read_addr", 32'(bht_read_addr), 32'd16);
        step();
        idle_inputs(); bht_prediction = 0; #1;
        chk("t1_pred_valid", 32'(pred_valid), 32'd1);
        chk("t1_pred_taken", 32'(pred_taken), 32'd0);
        chk("t1_next_pc", pred_next_pc, 32'h44);
        chk("t1_ready_in_lookup", 32'(fetch_ready), 32'd0);
        step();

        // resolve as taken -> mispredict
        idle_inputs(); resolve_valid = 1; resolve_taken = 1; #1;
        chk("t2_flush", 32'(flush), 32'd1);
        chk("t2_redirect", redirect_pc, 32'h80);
        chk("t2_write_addr", 32'(bht_write_addr), 32'd16);
        chk("t2_was_taken", 32'(bht_was_taken), 32'd1);
        chk("t2_bht_branch", 32'(bht_branch), 32'd1);
        chk("t2_ready_during_flush", 32'(fetch_ready), 32'd0);
        step();
        idle_inputs(); #1;
        chk("t2_misp_count", 32'(mispredict_count), 32'd1);
        chk("t2_branch_count", 32'(branch_count), 32'd1);
        chk("t2_flush_clear", 32'(flush), 32'd0);

        // fill the FIFO with four lookups
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1; fetch_pc = 32'h200 + 32'(i) * 32'h10;
            fetch_target = 32'h1000 + 32'(i) * 32'h100; #1;
            chk($sformatf("t3_ready_%0d", i), 32'(fetch_ready), 32'd1);
            chk($sformatf("t3_raddr_%0d", i), 32'(bht_read_addr), 32'(exp_raddr[i]));
            step();
            idle_inputs(); bht_prediction = (i % 2 == 1); #1;
            chk($sformatf("t3_next_pc_%0d", i), pred_next_pc, exp_next[i]);
            step();
        end
        idle_inputs(); fetch_req = 1; fetch_pc = 32'h240; #1;
        chk("t3_full_ready", 32'(fetch_ready), 32'd0);
        chk("t3_full_no_lookup", 32'(bht_en), 32'd0);
        resolve_valid = 1; resolve_taken = 0; #1;
        chk("t3_pop0_flush", 32'(flush), 32'd0);
        chk("t3_pop0_branch", 32'(bht_branch), 32'd1);
        chk("t3_pop0_ready", 32'(fetch_ready), 32'd0);
        step();
        idle_inputs(); #1;
        chk("t3_ready_back", 32'(fetch_ready), 32'd1);
        resolve_valid = 1; resolve_taken = 1; #1;
        chk("t3_pop1_flush", 32'(flush), 32'd0);
        chk("t3_pop1_waddr", 32'(bht_write_addr), 32'd4);
        step();
        idle_inputs(); resolve_valid = 1; #1;
        chk("t3_pop2_flush", 32'(flush), 32'd0);
        step();
        idle_inputs(); resolve_valid = 1; resolve_jump = 1; #1;
        chk("t3_pop3_flush", 32'(flush), 32'd0);
        chk("t3_pop3_jumped", 32'(bht_jumped), 32'd1);
        chk("t3_pop3_was_taken", 32'(bht_was_taken), 32'd0);
        chk("t3_pop3_waddr", 32'(bht_write_addr), 32'd12);
        step();
        idle_inputs(); #1;
        chk("t3_branch_count", 32'(branch_count), 32'd5);
        chk("t3_misp_count", 32'(mispredict_count), 32'd1);

        // mispredict resolve aborts the lookup of pc 0x100
        fetch_req = 1; fetch_pc = 32'h300; fetch_target = 32'h400; step();
        idle_inputs(); bht_prediction = 1; step();
        idle_inputs(); fetch_req = 1; fetch_pc = 32'h100; fetch_target = 32'h180; #1;
        chk("t4_ready", 32'(fetch_ready), 32'd1);
        step();
        idle_inputs(); bht_prediction = 1; resolve_valid = 1; #1;
        chk("t4_no_pred_valid", 32'(pred_valid), 32'd0);
        chk("t4_flush", 32'(flush), 32'd1);
        chk("t4_redirect", redirect_pc, 32'h304);
        step();
        idle_inputs(); fetch_req = 1; fetch_pc = 32'h54; fetch_target = 32'h600; #1;
        chk("t4_next_accept", 32'(fetch_ready), 32'd1);
        chk("t4_next_raddr", 32'(bht_read_addr), 32'd21);
        step();
        idle_inputs(); #1;
        chk("t4_next_pred_valid", 32'(pred_valid), 32'd1);
        chk("t4_next_pc", pred_next_pc, 32'h58);
        step();
        idle_inputs(); resolve_valid = 1; #1;
        chk("t4_resolve_only_entry", 32'(flush), 32'd0);
        step();

        // resolve with empty FIFO
        idle_inputs(); resolve_valid = 1; #1;
        chk("t5_no_branch", 32'(bht_branch), 32'd0);
        chk("t5_no_flush", 32'(flush), 32'd0);
        chk("t5_no_bht_en", 32'(bht_en), 32'd0);
        step();
        idle_inputs(); #1;
        chk("t5_underflow", 32'(underflow_err), 32'd1);
        chk("t5_branch_count", 32'(branch_count), 32'd7);
        chk("t5_misp_count", 32'(mispredict_count), 32'd2);
        step();
        chk("t5_underflow_sticky", 32'(underflow_err), 32'd1);
        rst = 1; step(); rst = 0; #1;
        chk("t5_underflow_cleared", 32'(underflow_err), 32'd0);
        chk("t5_count_cleared", 32'(branch_count), 32'd0);

        // saturation: more mispredicts than the counter range
        for (int i = 0; i < 70; i++) begin
            idle_inputs(); fetch_req = 1; fetch_pc = 32'h80; fetch_target = 32'hC0; step();
            idle_inputs(); step();
            idle_inputs(); resolve_valid = 1; resolve_taken = 1; step();
        end
        idle_inputs(); #1;
        chk("t6_misp_sat", 32'(mispredict_count), SAT);
        chk("t6_branch_sat", 32'(branch_count), SAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
